// File: rtl/reaction_mode_n_pkg.sv
// Shared types and constants for the multi-round reaction-timer game mode.
package reaction_mode_n_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StLit,
    StScore,
    StFault,
    StDone
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Random part of the pre-light delay is folded into 0..DlyRange-1 ticks.
  localparam int unsigned DlyRange = 1024;

  // All-ones pattern of a given width (w <= 63), truncated by the caller.
  function automatic logic [63:0] cnt_ones(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/reaction_mode_n_if.sv
// Control, player-input and display signals of the reaction-timer game mode.
interface reaction_mode_n_if #(
  parameter int unsigned N_LEDS = 8,
  parameter int unsigned CNT_W  = 24
);

  logic              enable;
  logic              start;
  logic              clr_hs;
  logic              tick;
  logic [N_LEDS-1:0] sw;
  logic [N_LEDS-1:0] led;
  logic [1:0]        status_led;
  logic [CNT_W-1:0]  react_time;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  highscore;
  logic [3:0]        round_idx;
  logic              session_done;

  // Mode select, tick generator and switches side.
  modport master (
    output enable, start, clr_hs, tick, sw,
    input  led, status_led, react_time, total, highscore, round_idx, session_done
  );

  // The game-mode block itself.
  modport slave (
    input  enable, start, clr_hs, tick, sw,
    output led, status_led, react_time, total, highscore, round_idx, session_done
  );

endinterface

// File: rtl/reaction_mode_n_lfsr16.sv
// 16-bit right-shifting Galois LFSR; any non-zero seed never reaches zero.
module reaction_mode_n_lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1,
  parameter logic [15:0] Taps = 16'hB400
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next value: shift right, fold the taps in when a one drops out.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);
    end
  end

  // State register with synchronous seed load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_mode_n.sv
// Multi-round reaction-timer game mode: random delay, one-hot target LED,
// reaction measurement in ticks, session total and clearable best-session score.
module reaction_mode_n
  import reaction_mode_n_pkg::*;
#(
  parameter int unsigned N_LEDS  = 8,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned ROUNDS  = 4,
  parameter int unsigned DLY_W   = 12,
  parameter int unsigned DLY_MIN = 500,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic             cin,
  input  logic             reset,
  reaction_mode_n_if.slave rm_if
);

  localparam logic [CNT_W-1:0]  CntOnes    = CNT_W'(cnt_ones(CNT_W));
  localparam logic [CNT_W-1:0]  TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [N_LEDS-1:0] LedOne     = N_LEDS'(1);
  localparam logic [3:0]        LastRound  = 4'(ROUNDS - 1);

  state_e            state_q;
  logic              start_q;
  logic [DLY_W-1:0]  dly_q;
  logic [3:0]        target_q;
  logic [CNT_W-1:0]  rt_cnt_q;
  logic [CNT_W-1:0]  react_time_q;
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  highscore_q;
  logic [N_LEDS-1:0] led_q;
  logic [1:0]        status_q;
  logic [3:0]        round_idx_q;
  logic              session_done_q;

  logic [15:0]       lfsr;
  logic              start_edge;
  logic [N_LEDS-1:0] target_oh;
  logic              sw_idle;
  logic              sw_hit;
  logic [CNT_W:0]    sum_full;
  logic [CNT_W-1:0]  total_sat;
  logic [CNT_W-1:0]  rt_inc;
  logic [DLY_W-1:0]  dly_load;
  logic [3:0]        target_load;

  reaction_mode_n_lfsr16 #(
    .Seed(LfsrSeed),
    .Taps(LfsrTaps)
  ) u_lfsr (
    .clk_i (cin),
    .rst_i (reset),
    .en_i  (1'b1),
    .lfsr_o(lfsr)
  );

  // Datapath helpers: start edge, target decode, saturating sums, round randomisation.
  always_comb begin
    start_edge  = rm_if.start & ~start_q;
    target_oh   = LedOne << target_q;
    sw_idle     = (rm_if.sw == '0);
    sw_hit      = (rm_if.sw == target_oh);
    sum_full    = {1'b0, total_q} + {1'b0, rt_cnt_q};
    total_sat   = sum_full[CNT_W] ? CntOnes : sum_full[CNT_W-1:0];
    rt_inc      = (rt_cnt_q == CntOnes) ? rt_cnt_q : rt_cnt_q + CNT_W'(1);
    dly_load    = DLY_W'(DLY_MIN + (32'(lfsr[DLY_W-1:0]) % DlyRange));
    target_load = 4'(32'(lfsr[15:12]) % N_LEDS);
  end

  // Game FSM with all outputs registered; clr_hs is applied last so it beats a DONE update.
  always_ff @(posedge cin) begin
    if (reset) begin
      state_q        <= StIdle;
      start_q        <= 1'b0;
      dly_q          <= '0;
      target_q       <= '0;
      rt_cnt_q       <= '0;
      react_time_q   <= '0;
      total_q        <= '0;
      highscore_q    <= CntOnes;
      led_q          <= '0;
      status_q       <= 2'b00;
      round_idx_q    <= '0;
      session_done_q <= 1'b0;
    end else begin
      start_q        <= rm_if.start;
      session_done_q <= 1'b0;
      if (!rm_if.enable) begin
        // Abort: displays of total/react_time stay for the user to read.
        state_q  <= StIdle;
        led_q    <= '0;
        status_q <= 2'b00;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_edge) begin
              state_q     <= StArm;
              status_q    <= 2'b01;
              total_q     <= '0;
              round_idx_q <= '0;
            end
          end
          StArm: begin
            dly_q    <= dly_load;
            target_q <= target_load;
            state_q  <= StWait;
          end
          StWait: begin
            if (!sw_idle) begin
              state_q  <= StFault;
              status_q <= 2'b10;
              led_q    <= '0;
            end else if (dly_q == '0) begin
              state_q  <= StLit;
              rt_cnt_q <= '0;
              led_q    <= target_oh;
            end else if (rm_if.tick) begin
              dly_q <= dly_q - DLY_W'(1);
            end
          end
          StLit: begin
            // A match is checked first so it wins over a coincident timeout.
            if (sw_hit) begin
              state_q      <= StScore;
              react_time_q <= rt_cnt_q;
              total_q      <= total_sat;
              led_q        <= '0;
            end else if (!sw_idle || (rt_cnt_q == TimeoutCnt)) begin
              state_q  <= StFault;
              status_q <= 2'b10;
              led_q    <= '0;
            end else if (rm_if.tick) begin
              rt_cnt_q <= rt_inc;
            end
          end
          StScore: begin
            if (round_idx_q == LastRound) begin
              state_q        <= StDone;
              status_q       <= 2'b00;
              session_done_q <= 1'b1;
            end else if (sw_idle) begin
              state_q     <= StArm;
              round_idx_q <= round_idx_q + 4'd1;
            end
          end
          StFault: begin
            // Restart goes straight to ARM as a fresh session.
            if (start_edge && sw_idle) begin
              state_q     <= StArm;
              status_q    <= 2'b01;
              total_q     <= '0;
              round_idx_q <= '0;
            end
          end
          StDone: begin
            state_q <= StIdle;
            if (total_q < highscore_q) begin
              highscore_q <= total_q;
            end
          end
          default: begin
            state_q  <= StIdle;
            status_q <= 2'b00;
            led_q    <= '0;
          end
        endcase
      end
      if (rm_if.clr_hs) begin
        highscore_q <= CntOnes;
      end
    end
  end

  assign rm_if.led          = led_q;
  assign rm_if.status_led   = status_q;
  assign rm_if.react_time   = react_time_q;
  assign rm_if.total        = total_q;
  assign rm_if.highscore    = highscore_q;
  assign rm_if.round_idx    = round_idx_q;
  assign rm_if.session_done = session_done_q;

endmodule

// File: tb/tb_reaction_mode_n.sv
// Directed bench for reaction_mode_n with two rounds per session.
module tb_reaction_mode_n;

  logic cin = 1'b0;
  logic reset;

  reaction_mode_n_if #(.N_LEDS(8), .CNT_W(24)) bus_if ();

  reaction_mode_n #(
    .N_LEDS (8),
    .CNT_W  (24),
    .ROUNDS (2),
    .DLY_W  (12),
    .DLY_MIN(500),
    .TIMEOUT(2000)
  ) dut (
    .cin  (cin),
    .reset(reset),
    .rm_if(bus_if)
  );

  always #5 cin = ~cin;

  // Reference LFSR: right-shift Galois, taps 0xB400, seed 0xACE1.
  logic [15:0] m_lfsr;
  always @(posedge cin) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    int r0;
    int r1;
    int tdiv;
    int exp_total;
    int exp_hs;
    bit clr;
  } vec_t;

  vec_t vecs[5];
  int   checks   = 0;
  int   failures = 0;
  int   tdiv     = 1;
  int   ph       = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Advance to the next falling edge and set the tick for the following rising edge.
  task automatic cyc();
    @(negedge cin);
    ph++;
    if (tdiv <= 1) bus_if.tick = 1'b1;
    else           bus_if.tick = ((ph % tdiv) == 0);
  endtask

  // Called on the falling edge right after ARM is entered.
  task automatic wait_light();
    logic [15:0] m;
    logic [7:0]  exp_led;
    int          d;
    int          n;
    m       = m_lfsr;
    exp_led = 8'b1 << (m[15:12] % 8);
    d       = 500 + int'(m[9:0]);
    n       = 0;
    while (bus_if.led == 8'h00 && n < 6000) begin
      cyc();
      n++;
    end
    chk("target_led", {24'h0, bus_if.led}, {24'h0, exp_led});
    if (tdiv == 1) chk("wait_len", n, d + 2);
    chk("lit_status", {30'h0, bus_if.status_led}, 32'd1);
  endtask

  // Let r ticks elapse in LIT, then present the lit switch.
  task automatic press(input int r);
    int cnt;
    cnt = 0;
    while (cnt < r) begin
      if (bus_if.tick) cnt++;
      cyc();
    end
    bus_if.sw = bus_if.led;
    cyc();
  endtask

  task automatic run_session(input vec_t v);
    tdiv         = v.tdiv;
    bus_if.sw    = 8'h00;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    chk("arm_round0", {28'h0, bus_if.round_idx}, 32'd0);
    chk("arm_total_clr", {8'h0, bus_if.total}, 32'd0);
    wait_light();
    press(v.r0);
    chk("react_r0", {8'h0, bus_if.react_time}, v.r0);
    chk("total_r0", {8'h0, bus_if.total}, v.r0);
    bus_if.sw = 8'h00;
    cyc();
    chk("round_idx1", {28'h0, bus_if.round_idx}, 32'd1);
    wait_light();
    press(v.r1);
    chk("react_r1", {8'h0, bus_if.react_time}, v.r1);
    cyc();
    chk("session_done", {31'h0, bus_if.session_done}, 32'd1);
    chk("session_total", {8'h0, bus_if.total}, v.exp_total);
    if (v.clr) bus_if.clr_hs = 1'b1;
    cyc();
    bus_if.clr_hs = 1'b0;
    chk("done_pulse_end", {31'h0, bus_if.session_done}, 32'd0);
    chk("highscore", {8'h0, bus_if.highscore}, v.exp_hs);
    chk("idle_status", {30'h0, bus_if.status_led}, 32'd0);
    bus_if.sw = 8'h00;
    tdiv      = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"}, {24'h0, bus_if.led}, 32'd0);
    chk({tag, "_status"}, {30'h0, bus_if.status_led}, 32'd0);
    chk({tag, "_react"}, {8'h0, bus_if.react_time}, 32'd0);
    chk({tag, "_total"}, {8'h0, bus_if.total}, 32'd0);
    chk({tag, "_round"}, {28'h0, bus_if.round_idx}, 32'd0);
    chk({tag, "_done"}, {31'h0, bus_if.session_done}, 32'd0);
    chk({tag, "_hs"}, {8'h0, bus_if.highscore}, 32'h00FF_FFFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{r0: 37,  r1: 120, tdiv: 1, exp_total: 157, exp_hs: 157,        clr: 1'b0};
    vecs[1] = '{r0: 100, r1: 100, tdiv: 3, exp_total: 200, exp_hs: 157,        clr: 1'b0};
    vecs[2] = '{r0: 40,  r1: 50,  tdiv: 1, exp_total: 90,  exp_hs: 90,         clr: 1'b0};
    vecs[3] = '{r0: 10,  r1: 10,  tdiv: 1, exp_total: 20,  exp_hs: 20,         clr: 1'b0};
    vecs[4] = '{r0: 5,   r1: 6,   tdiv: 1, exp_total: 11,  exp_hs: 'h00FF_FFFF, clr: 1'b1};

    reset         = 1'b1;
    bus_if.enable = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.clr_hs = 1'b0;
    bus_if.tick   = 1'b1;
    bus_if.sw     = 8'h00;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk_reset_vals("por");

    // Start edge while the mode is deselected must not arm.
    bus_if.enable = 1'b0;
    bus_if.start  = 1'b1;
    cyc();
    cyc();
    chk("disabled_no_arm", {30'h0, bus_if.status_led}, 32'd0);
    bus_if.start  = 1'b0;
    bus_if.enable = 1'b1;
    cyc();

    for (int i = 0; i < 3; i++) run_session(vecs[i]);

    // False start during WAIT, then restart from FAULT.
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    cyc();
    chk("wait_status", {30'h0, bus_if.status_led}, 32'd1);
    bus_if.sw = 8'h01;
    cyc();
    chk("false_start", {30'h0, bus_if.status_led}, 32'd2);
    chk("fault_led", {24'h0, bus_if.led}, 32'd0);
    chk("fault_hs", {8'h0, bus_if.highscore}, 32'd90);
    bus_if.sw = 8'h00;
    cyc();
    chk("fault_hold", {30'h0, bus_if.status_led}, 32'd2);
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    chk("rearm_status", {30'h0, bus_if.status_led}, 32'd1);
    chk("rearm_round", {28'h0, bus_if.round_idx}, 32'd0);
    chk("rearm_total", {8'h0, bus_if.total}, 32'd0);

    // Wrong switch while lit.
    wait_light();
    bus_if.sw = {bus_if.led[6:0], bus_if.led[7]};
    cyc();
    chk("wrong_switch", {30'h0, bus_if.status_led}, 32'd2);
    chk("wrong_led", {24'h0, bus_if.led}, 32'd0);

    // Timeout: 2000 ticks with no input.
    bus_if.sw    = 8'h00;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    wait_light();
    repeat (2000) cyc();
    chk("pre_timeout", {30'h0, bus_if.status_led}, 32'd1);
    chk("pre_timeout_lit", {31'h0, (bus_if.led != 8'h00)}, 32'd1);
    cyc();
    chk("timeout", {30'h0, bus_if.status_led}, 32'd2);

    // Match on the 2000th tick wins over timeout.
    bus_if.sw    = 8'h00;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    wait_light();
    press(2000);
    chk("late_match_react", {8'h0, bus_if.react_time}, 32'd2000);
    chk("late_match_status", {30'h0, bus_if.status_led}, 32'd1);

    // Enable drop while lit in round 1.
    bus_if.sw = 8'h00;
    cyc();
    wait_light();
    bus_if.enable = 1'b0;
    cyc();
    chk("abort_led", {24'h0, bus_if.led}, 32'd0);
    chk("abort_status", {30'h0, bus_if.status_led}, 32'd0);
    chk("abort_hs", {8'h0, bus_if.highscore}, 32'd90);
    chk("abort_total", {8'h0, bus_if.total}, 32'd2000);
    chk("abort_react", {8'h0, bus_if.react_time}, 32'd2000);
    bus_if.enable = 1'b1;
    cyc();
    chk("abort_stays_idle", {30'h0, bus_if.status_led}, 32'd0);

    // Reset in the middle of WAIT.
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_reset_vals("wait_rst");

    run_session(vecs[3]);
    bus_if.clr_hs = 1'b1;
    cyc();
    bus_if.clr_hs = 1'b0;
    chk("clr_hs", {8'h0, bus_if.highscore}, 32'h00FF_FFFF);
    run_session(vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
